// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: round-robin line-burst arbiter onto one main-memory word port; define MEM_ARB_FIXED_PRIO_EN for fixed priority
module line_mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int WORD_SIZE = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_BITS = 32,
  localparam int BW = $clog2(WORDS_PER_LINE),
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           MEM_CLK,
  input  logic                           RST,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS-1:0]           we,
  input  logic [NUM_PORTS*ADDR_BITS-1:0] addr,
  input  logic [NUM_PORTS*WORD_SIZE-1:0] wdata,
  output logic [NUM_PORTS-1:0]           gnt,
  output logic [NUM_PORTS-1:0]           beat,
  output logic [BW-1:0]                  beat_idx,
  output logic [WORD_SIZE-1:0]           rdata,
  output logic [NUM_PORTS-1:0]           done,
  output logic                           mm_re,
  output logic                           mm_we,
  output logic [ADDR_BITS-3:0]           mm_addr,
  output logic [WORD_SIZE-1:0]           mm_wdata,
  input  logic [WORD_SIZE-1:0]           mm_rdata,
  input  logic                           mm_valid
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  localparam int LW = ADDR_BITS - 2 - BW;
  logic [1:0] state;
  logic [PW-1:0] g, win, idx;
  logic we_l, busy;
  logic [LW-1:0] base;
  logic [BW-1:0] cnt;
  logic [NUM_PORTS-1:0] sel;
  logic [NUM_PORTS*ADDR_BITS-1:0] unused_addr;
  assign unused_addr = addr;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [PW-1:0] rr;
`endif
  // pick the winner; walking downward lets the nearest requester overwrite farther ones
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      idx = PW'(k);
`else
      idx = PW'((int'(rr) + k) % NUM_PORTS);
`endif
      if (req[idx]) win = idx;
    end
  end
  // burst sequencer: latch grant context, count beats, pulse done
  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      state <= IDLE;
      g <= '0;
      we_l <= 1'b0;
      base <= '0;
      cnt <= '0;
      rdata <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (|req) begin
          state <= BUSY;
          g <= win;
          we_l <= we[win];
          base <= addr[win*ADDR_BITS+BW+2 +: LW];
        end
        BUSY: if (mm_valid) begin
          cnt <= cnt + 1'b1;
          if (!we_l) rdata <= mm_rdata;
          if (&cnt) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
          rr <= PW'((int'(g) + 1) % NUM_PORTS);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
  // outputs decode from the registered state so grant lands one cycle after request
  always_comb begin
    busy = state == BUSY;
    sel = NUM_PORTS'(1) << g;
    gnt = busy ? sel : '0;
    beat = busy && mm_valid ? sel : '0;
    done = state == DONE ? sel : '0;
    mm_re = busy & ~we_l;
    mm_we = busy & we_l;
    beat_idx = busy ? cnt : '0;
    mm_addr = busy ? {base, cnt} : '0;
    mm_wdata = busy ? wdata[g*WORD_SIZE +: WORD_SIZE] : '0;
  end
endmodule
